// File: rtl/axil_rr_arbiter_2to1_if.sv
// AXI4-Lite bundle shared by the arbiter's two upstream ports and its downstream port.
// The master modport drives addresses, data and the response-ready signals.
interface axil_rr_arbiter_2to1_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   awaddr;
    logic [2:0]          awprot;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid;
    logic                wready;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;
    logic [ADDR_W-1:0]   araddr;
    logic [2:0]          arprot;
    logic                arvalid;
    logic                arready;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rvalid;
    logic                rready;

    modport master (
        output awaddr, awprot, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input bresp, bvalid, output bready,
        output araddr, arprot, arvalid, input arready,
        input rdata, rresp, rvalid, output rready
    );

    modport slave (
        input awaddr, awprot, awvalid, output awready,
        input wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input araddr, arprot, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );
endinterface

// File: rtl/axil_rr_arbiter_2to1.sv
// Two-master AXI4-Lite arbiter: one whole write or read transaction at a time,
// round-robin over the four sources S0 write, S0 read, S1 write, S1 read.
module axil_rr_arbiter_2to1 #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
) (
    input  logic                          ACLK,
    input  logic                          ARESET,
    axil_rr_arbiter_2to1_if.slave         s0_axi,
    axil_rr_arbiter_2to1_if.slave         s1_axi,
    axil_rr_arbiter_2to1_if.master        m_axi,
    output logic [1:0]                    GRANT,
    output logic                          BUSY
);

    localparam int STRB_W = C_S_AXI_DATA_WIDTH / 8;

    typedef enum logic [2:0] {IDLE, WR_ADDR, WR_RESP, RD_ADDR, RD_DATA} state_t;

    state_t state, state_nxt;
    logic [1:0] grant, grant_nxt;
    logic       aw_done, aw_done_nxt;
    logic       w_done, w_done_nxt;

    logic [3:0] req;
    logic       sel;
    logic       found;
    logic [1:0] pick;
    logic [1:0] cand;

    logic [C_S_AXI_ADDR_WIDTH-1:0] sel_awaddr, sel_araddr;
    logic [2:0]                    sel_awprot, sel_arprot;
    logic [C_S_AXI_DATA_WIDTH-1:0] sel_wdata;
    logic [STRB_W-1:0]             sel_wstrb;
    logic sel_awvalid, sel_wvalid, sel_bready, sel_arvalid, sel_rready;

    logic aw_hs, w_hs, b_hs, ar_hs, r_hs;

    logic                          aw_rdy, w_rdy, ar_rdy, b_vld, r_vld;
    logic [1:0]                    b_resp, r_resp;
    logic [C_S_AXI_DATA_WIDTH-1:0] r_data;

    // Request bit index equals the GRANT encoding.
    assign req = {s1_axi.arvalid, s1_axi.awvalid & s1_axi.wvalid,
                  s0_axi.arvalid, s0_axi.awvalid & s0_axi.wvalid};
    assign sel = grant[1];

    always_comb begin
        sel_awaddr  = sel ? s1_axi.awaddr  : s0_axi.awaddr;
        sel_awprot  = sel ? s1_axi.awprot  : s0_axi.awprot;
        sel_awvalid = sel ? s1_axi.awvalid : s0_axi.awvalid;
        sel_wdata   = sel ? s1_axi.wdata   : s0_axi.wdata;
        sel_wstrb   = sel ? s1_axi.wstrb   : s0_axi.wstrb;
        sel_wvalid  = sel ? s1_axi.wvalid  : s0_axi.wvalid;
        sel_bready  = sel ? s1_axi.bready  : s0_axi.bready;
        sel_araddr  = sel ? s1_axi.araddr  : s0_axi.araddr;
        sel_arprot  = sel ? s1_axi.arprot  : s0_axi.arprot;
        sel_arvalid = sel ? s1_axi.arvalid : s0_axi.arvalid;
        sel_rready  = sel ? s1_axi.rready  : s0_axi.rready;
    end

    assign aw_hs = (state == WR_ADDR) && sel_awvalid && !aw_done && m_axi.awready;
    assign w_hs  = (state == WR_ADDR) && sel_wvalid  && !w_done  && m_axi.wready;
    assign b_hs  = (state == WR_RESP) && m_axi.bvalid && sel_bready;
    assign ar_hs = (state == RD_ADDR) && sel_arvalid && m_axi.arready;
    assign r_hs  = (state == RD_DATA) && m_axi.rvalid && sel_rready;

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state   <= IDLE;
            grant   <= 2'd3;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            state   <= state_nxt;
            grant   <= grant_nxt;
            aw_done <= aw_done_nxt;
            w_done  <= w_done_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        grant_nxt   = grant;
        aw_done_nxt = aw_done;
        w_done_nxt  = w_done;
        found       = 1'b0;
        pick        = grant;
        cand        = grant;
        unique case (state)
            IDLE: begin
                // Scan starts one past the last grant; the last grant itself comes last.
                for (int i = 1; i <= 4; i++) begin
                    cand = grant + 2'(i);
                    if (!found && req[cand]) begin
                        found = 1'b1;
                        pick  = cand;
                    end
                end
                if (found) begin
                    grant_nxt = pick;
                    state_nxt = pick[0] ? RD_ADDR : WR_ADDR;
                end
            end
            WR_ADDR: begin
                if (aw_hs) aw_done_nxt = 1'b1;
                if (w_hs)  w_done_nxt  = 1'b1;
                if ((aw_done || aw_hs) && (w_done || w_hs)) state_nxt = WR_RESP;
            end
            WR_RESP: begin
                if (b_hs) begin
                    state_nxt   = IDLE;
                    aw_done_nxt = 1'b0;
                    w_done_nxt  = 1'b0;
                end
            end
            RD_ADDR: if (ar_hs) state_nxt = RD_DATA;
            RD_DATA: if (r_hs)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        m_axi.awaddr  = '0;
        m_axi.awprot  = '0;
        m_axi.awvalid = 1'b0;
        m_axi.wdata   = '0;
        m_axi.wstrb   = '0;
        m_axi.wvalid  = 1'b0;
        m_axi.bready  = 1'b0;
        m_axi.araddr  = '0;
        m_axi.arprot  = '0;
        m_axi.arvalid = 1'b0;
        m_axi.rready  = 1'b0;
        aw_rdy = 1'b0;
        w_rdy  = 1'b0;
        ar_rdy = 1'b0;
        b_vld  = 1'b0;
        b_resp = '0;
        r_vld  = 1'b0;
        r_resp = '0;
        r_data = '0;
        unique case (state)
            WR_ADDR: begin
                // A channel that already handshook is masked so it is never issued twice.
                m_axi.awaddr  = sel_awaddr;
                m_axi.awprot  = sel_awprot;
                m_axi.awvalid = sel_awvalid && !aw_done;
                m_axi.wdata   = sel_wdata;
                m_axi.wstrb   = sel_wstrb;
                m_axi.wvalid  = sel_wvalid && !w_done;
                aw_rdy        = m_axi.awready && !aw_done;
                w_rdy         = m_axi.wready && !w_done;
            end
            WR_RESP: begin
                b_vld        = m_axi.bvalid;
                b_resp       = m_axi.bresp;
                m_axi.bready = sel_bready;
            end
            RD_ADDR: begin
                m_axi.araddr  = sel_araddr;
                m_axi.arprot  = sel_arprot;
                m_axi.arvalid = sel_arvalid;
                ar_rdy        = m_axi.arready;
            end
            RD_DATA: begin
                r_vld        = m_axi.rvalid;
                r_resp       = m_axi.rresp;
                r_data       = m_axi.rdata;
                m_axi.rready = sel_rready;
            end
            default: ;
        endcase
    end

    always_comb begin
        s0_axi.awready = aw_rdy && !sel;
        s0_axi.wready  = w_rdy  && !sel;
        s0_axi.bvalid  = b_vld  && !sel;
        s0_axi.bresp   = sel ? 2'b00 : b_resp;
        s0_axi.arready = ar_rdy && !sel;
        s0_axi.rvalid  = r_vld  && !sel;
        s0_axi.rresp   = sel ? 2'b00 : r_resp;
        s0_axi.rdata   = sel ? '0 : r_data;
        s1_axi.awready = aw_rdy && sel;
        s1_axi.wready  = w_rdy  && sel;
        s1_axi.bvalid  = b_vld  && sel;
        s1_axi.bresp   = sel ? b_resp : 2'b00;
        s1_axi.arready = ar_rdy && sel;
        s1_axi.rvalid  = r_vld  && sel;
        s1_axi.rresp   = sel ? r_resp : 2'b00;
        s1_axi.rdata   = sel ? r_data : '0;
    end

    assign GRANT = grant;
    assign BUSY  = (state != IDLE);

endmodule

// File: tb/tb_axil_rr_arbiter_2to1.sv
// Directed bench for axil_rr_arbiter_2to1 with a 4 x 32-bit register slave model
// behind the master port.
module tb_axil_rr_arbiter_2to1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    axil_rr_arbiter_2to1_if #(.ADDR_W(4), .DATA_W(32)) s0_if ();
    axil_rr_arbiter_2to1_if #(.ADDR_W(4), .DATA_W(32)) s1_if ();
    axil_rr_arbiter_2to1_if #(.ADDR_W(4), .DATA_W(32)) m_if ();

    logic [1:0] grant;
    logic       busy;

    axil_rr_arbiter_2to1 #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(4)) dut (
        .ACLK   (clk),
        .ARESET (rst),
        .s0_axi (s0_if),
        .s1_axi (s1_if),
        .m_axi  (m_if),
        .GRANT  (grant),
        .BUSY   (busy)
    );

    // Upstream master drives, indexed by port
    logic        aw_v[2], w_v[2], ar_v[2], b_r[2], r_r[2];
    logic [3:0]  aw_a[2], ar_a[2];
    logic [31:0] w_d[2];
    logic        awr[2], wr[2], bv[2], arr[2], rv[2];
    logic [1:0]  br[2], rr[2];
    logic [31:0] rd[2];

    assign s0_if.awaddr = aw_a[0]; assign s0_if.awprot = 3'd0; assign s0_if.awvalid = aw_v[0];
    assign s0_if.wdata = w_d[0];   assign s0_if.wstrb = 4'hF;  assign s0_if.wvalid = w_v[0];
    assign s0_if.bready = b_r[0];  assign s0_if.araddr = ar_a[0]; assign s0_if.arprot = 3'd0;
    assign s0_if.arvalid = ar_v[0]; assign s0_if.rready = r_r[0];
    assign s1_if.awaddr = aw_a[1]; assign s1_if.awprot = 3'd0; assign s1_if.awvalid = aw_v[1];
    assign s1_if.wdata = w_d[1];   assign s1_if.wstrb = 4'hF;  assign s1_if.wvalid = w_v[1];
    assign s1_if.bready = b_r[1];  assign s1_if.araddr = ar_a[1]; assign s1_if.arprot = 3'd0;
    assign s1_if.arvalid = ar_v[1]; assign s1_if.rready = r_r[1];

    assign awr[0] = s0_if.awready; assign wr[0] = s0_if.wready; assign bv[0] = s0_if.bvalid;
    assign arr[0] = s0_if.arready; assign rv[0] = s0_if.rvalid; assign br[0] = s0_if.bresp;
    assign rr[0] = s0_if.rresp;    assign rd[0] = s0_if.rdata;
    assign awr[1] = s1_if.awready; assign wr[1] = s1_if.wready; assign bv[1] = s1_if.bvalid;
    assign arr[1] = s1_if.arready; assign rv[1] = s1_if.rvalid; assign br[1] = s1_if.bresp;
    assign rr[1] = s1_if.rresp;    assign rd[1] = s1_if.rdata;

    // Register slave model: AW and W accepted independently, B once both are in
    logic [31:0] regs[4];
    logic        aw_got, w_got, s_bv, s_rv, aw_en;
    logic [3:0]  aw_lat;
    logic [31:0] w_lat, s_rd;
    int          aw_cnt = 0, w_cnt = 0, b_cnt = 0;

    assign m_if.awready = aw_en && !aw_got && !s_bv;
    assign m_if.wready  = !w_got && !s_bv;
    assign m_if.bvalid  = s_bv;
    assign m_if.bresp   = 2'b00;
    assign m_if.arready = !s_rv;
    assign m_if.rvalid  = s_rv;
    assign m_if.rdata   = s_rd;
    assign m_if.rresp   = 2'b00;

    always @(posedge clk) begin
        logic aw_hs, w_hs;
        logic [3:0] a_now;
        logic [31:0] d_now;
        aw_hs = m_if.awvalid && m_if.awready;
        w_hs  = m_if.wvalid && m_if.wready;
        a_now = aw_got ? aw_lat : m_if.awaddr;
        d_now = w_got ? w_lat : m_if.wdata;
        if (aw_hs) aw_cnt <= aw_cnt + 1;
        if (w_hs)  w_cnt  <= w_cnt + 1;
        if (s_bv && m_if.bready) b_cnt <= b_cnt + 1;
        if (rst) begin
            aw_got <= 1'b0; w_got <= 1'b0; s_bv <= 1'b0; s_rv <= 1'b0;
            s_rd <= '0; aw_lat <= '0; w_lat <= '0;
            for (int i = 0; i < 4; i++) regs[i] <= '0;
        end else begin
            if ((aw_got || aw_hs) && (w_got || w_hs) && !s_bv) begin
                regs[a_now[3:2]] <= d_now;
                s_bv   <= 1'b1;
                aw_got <= 1'b0;
                w_got  <= 1'b0;
            end else begin
                if (aw_hs) begin aw_got <= 1'b1; aw_lat <= m_if.awaddr; end
                if (w_hs)  begin w_got  <= 1'b1; w_lat  <= m_if.wdata;  end
            end
            if (s_bv && m_if.bready) s_bv <= 1'b0;
            if (m_if.arvalid && m_if.arready) begin
                s_rv <= 1'b1;
                s_rd <= regs[m_if.araddr[3:2]];
            end
            if (s_rv && m_if.rready) s_rv <= 1'b0;
        end
    end

    // Grant log (one entry per new ownership) and S1 activity counter
    logic [1:0] grant_log[$];
    logic       busy_prev = 1'b0;
    int         s1_seen = 0;
    always @(negedge clk) begin
        if (busy === 1'b1 && busy_prev !== 1'b1) grant_log.push_back(grant);
        busy_prev = busy;
        if (s1_if.awready || s1_if.wready || s1_if.bvalid || s1_if.arready || s1_if.rvalid)
            s1_seen++;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_txn(input int p, input logic [3:0] a, input logic [31:0] d,
                             output logic [1:0] resp);
        logic ha, hw, hb, done;
        done = 1'b0;
        resp = 2'bxx;
        aw_a[p] = a; w_d[p] = d; aw_v[p] = 1'b1; w_v[p] = 1'b1; b_r[p] = 1'b1;
        for (int n = 0; n < 60 && !done; n++) begin
            @(negedge clk);
            ha = aw_v[p] & awr[p];
            hw = w_v[p] & wr[p];
            hb = bv[p] & b_r[p];
            if (hb) resp = br[p];
            tick();
            if (ha) aw_v[p] = 1'b0;
            if (hw) w_v[p] = 1'b0;
            if (hb) begin b_r[p] = 1'b0; done = 1'b1; end
        end
        check($sformatf("wr_done_p%0d", p), 32'(done), 32'd1);
    endtask

    task automatic read_txn(input int p, input logic [3:0] a,
                            output logic [31:0] data, output logic [1:0] resp);
        logic ha, hr, done;
        done = 1'b0;
        data = 'x;
        resp = 2'bxx;
        ar_a[p] = a; ar_v[p] = 1'b1; r_r[p] = 1'b1;
        for (int n = 0; n < 60 && !done; n++) begin
            @(negedge clk);
            ha = ar_v[p] & arr[p];
            hr = rv[p] & r_r[p];
            if (hr) begin data = rd[p]; resp = rr[p]; end
            tick();
            if (ha) ar_v[p] = 1'b0;
            if (hr) begin r_r[p] = 1'b0; done = 1'b1; end
        end
        check($sformatf("rd_done_p%0d", p), 32'(done), 32'd1);
    endtask

    task automatic idle_all();
        for (int p = 0; p < 2; p++) begin
            aw_v[p] = 1'b0; w_v[p] = 1'b0; ar_v[p] = 1'b0; b_r[p] = 1'b0; r_r[p] = 1'b0;
            aw_a[p] = '0; ar_a[p] = '0; w_d[p] = '0;
        end
    endtask

    initial begin
        logic [1:0]  r0, r1;
        logic [31:0] rdat;
        int base, bound, cnt[4];
        int aw0, w0, b0, s1base;

        idle_all();
        aw_en = 1'b1;
        rst = 1'b1;

        // Reset held with every upstream VALID and READY high
        for (int p = 0; p < 2; p++) begin
            aw_v[p] = 1'b1; w_v[p] = 1'b1; ar_v[p] = 1'b1; b_r[p] = 1'b1; r_r[p] = 1'b1;
            w_d[p] = 32'(p + 16);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            check("rst_outputs",
                  32'({s0_if.awready, s0_if.wready, s0_if.bvalid, s0_if.arready, s0_if.rvalid,
                       s1_if.awready, s1_if.wready, s1_if.bvalid, s1_if.arready, s1_if.rvalid,
                       m_if.awvalid, m_if.wvalid, m_if.bready, m_if.arvalid, m_if.rready}),
                  32'd0);
        end
        check("rst_grant", 32'(grant), 32'd3);
        check("rst_busy", 32'(busy), 32'd0);

        // Fairness: all four sources request continuously
        base = grant_log.size();
        rst = 1'b0;
        bound = 0;
        while (grant_log.size() < base + 16 && bound < 400) begin
            @(posedge clk);
            bound++;
        end
        #1;
        check("fair_grants_seen", 32'(grant_log.size() >= base + 16), 32'd1);
        for (int i = 0; i < 4; i++) cnt[i] = 0;
        for (int i = 0; i < 16 && base + i < grant_log.size(); i++) begin
            check($sformatf("fair_grant_%0d", i), 32'(grant_log[base + i]), 32'(i % 4));
            cnt[grant_log[base + i]]++;
        end
        for (int i = 0; i < 4; i++) check($sformatf("fair_count_src%0d", i), 32'(cnt[i]), 32'd4);

        // Clean restart
        idle_all();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        tick();

        // Single S0 write then read; S1 must stay quiet
        s1base = s1_seen;
        write_txn(0, 4'h0, 32'h0000_0001, r0);
        check("s0_wr_bresp", 32'(r0), 32'd0);
        check("s0_wr_grant", 32'(grant), 32'd0);
        ar_a[0] = 4'h0; ar_v[0] = 1'b1; r_r[0] = 1'b1;
        @(negedge clk);
        check("rd_lat_idle_arvalid", 32'(m_if.arvalid), 32'd0);
        @(negedge clk);
        check("rd_lat_arvalid", 32'(m_if.arvalid), 32'd1);
        check("rd_arready_pass", 32'(s0_if.arready), 32'd1);
        check("rd_grant", 32'(grant), 32'd1);
        @(posedge clk); #1;
        ar_v[0] = 1'b0;
        @(negedge clk);
        check("rd_rvalid", 32'(rv[0]), 32'd1);
        check("rd_rdata", rd[0], 32'h0000_0001);
        check("rd_rresp", 32'(rr[0]), 32'd0);
        @(posedge clk); #1;
        r_r[0] = 1'b0;
        @(negedge clk);
        check("rd_busy_done", 32'(busy), 32'd0);
        check("s1_never_ready", 32'(s1_seen - s1base), 32'd0);

        // Skewed S1 write: W arrives 3 cycles after AW, slave AWREADY low 2 cycles
        @(posedge clk); #1;
        aw0 = aw_cnt; w0 = w_cnt; b0 = b_cnt;
        aw_en = 1'b0;
        aw_a[1] = 4'h8; w_d[1] = 32'hCAFE_0001; aw_v[1] = 1'b1; b_r[1] = 1'b1;
        tick(); tick(); tick();
        w_v[1] = 1'b1;
        bound = 0;
        do begin @(negedge clk); bound++; end while (m_if.awvalid !== 1'b1 && bound < 10);
        check("skew_awvalid_seen", 32'(m_if.awvalid), 32'd1);
        check("skew_grant", 32'(grant), 32'd2);
        tick();
        check("skew_wvalid_masked", 32'(m_if.wvalid), 32'd0);
        check("skew_wready_masked", 32'(wr[1]), 32'd0);
        check("skew_awvalid_held", 32'(m_if.awvalid), 32'd1);
        tick();
        aw_en = 1'b1;
        bound = 0;
        do begin @(negedge clk); bound++; end while (bv[1] !== 1'b1 && bound < 10);
        check("skew_bvalid", 32'(bv[1]), 32'd1);
        tick();
        aw_v[1] = 1'b0; w_v[1] = 1'b0; b_r[1] = 1'b0;
        check("skew_aw_count", 32'(aw_cnt - aw0), 32'd1);
        check("skew_w_count", 32'(w_cnt - w0), 32'd1);
        check("skew_b_count", 32'(b_cnt - b0), 32'd1);
        read_txn(1, 4'h8, rdat, r1);
        check("skew_readback", rdat, 32'hCAFE_0001);

        // Reset while the response is pending with BREADY low
        aw_a[0] = 4'hC; w_d[0] = 32'h0000_1234; aw_v[0] = 1'b1; w_v[0] = 1'b1; b_r[0] = 1'b0;
        bound = 0;
        do begin @(negedge clk); bound++; end while (bv[0] !== 1'b1 && bound < 10);
        check("rstmid_bvalid_before", 32'(bv[0]), 32'd1);
        check("rstmid_busy_before", 32'(busy), 32'd1);
        aw_v[0] = 1'b0; w_v[0] = 1'b0;
        rst = 1'b1;
        tick();
        check("rstmid_busy", 32'(busy), 32'd0);
        check("rstmid_grant", 32'(grant), 32'd3);
        check("rstmid_bvalid", 32'({bv[0], bv[1]}), 32'd0);
        rst = 1'b0;
        tick();

        // Contention: both masters write 0x4 in the same cycle
        base = grant_log.size();
        fork
            write_txn(0, 4'h4, 32'hA5A5_A5A5, r0);
            write_txn(1, 4'h4, 32'h5A5A_5A5A, r1);
        join
        check("cont_bresp0", 32'(r0), 32'd0);
        check("cont_bresp1", 32'(r1), 32'd0);
        check("cont_grants", 32'(grant_log.size() - base), 32'd2);
        if (grant_log.size() >= base + 2) begin
            check("cont_first", 32'(grant_log[base]), 32'd0);
            check("cont_second", 32'(grant_log[base + 1]), 32'd2);
        end
        read_txn(0, 4'h4, rdat, r0);
        check("cont_readback", rdat, 32'h5A5A_5A5A);
        check("cont_rresp", 32'(r0), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
